// File: rtl/warp_scheduler_pkg.sv
// Shared types for the warp scheduler: pipeline phase, per-warp status and
// the architectural upper bound on warps per core.
package warp_scheduler_pkg;

  localparam int MAX_WARPS = 16;

  typedef enum logic [2:0] {
    WARP_IDLE     = 3'd0,
    WARP_SCHEDULE = 3'd1,
    WARP_FETCH    = 3'd2,
    WARP_DECODE   = 3'd3,
    WARP_REQUEST  = 3'd4,
    WARP_WAIT     = 3'd5,
    WARP_EXECUTE  = 3'd6,
    WARP_UPDATE   = 3'd7
  } warp_state_t;

  typedef enum logic [1:0] {
    W_OFF   = 2'd0,
    W_READY = 2'd1,
    W_SYNC  = 2'd2,
    W_HALT  = 2'd3
  } warp_status_t;

endpackage

// File: rtl/warp_scheduler_if.sv
// Scheduler <-> core bus: launch controls, instruction fetch handshake,
// registered decoder flags, LSU completion, branch redirect and the shared
// phase/warp-id broadcast.
//   master: the scheduler (drives fetch request, phase, active warp, done)
//   slave : the rest of the core (launch, fetch/LSU responses, decoder flags)
interface warp_scheduler_if #(
  parameter int NUM_WARPS = 4,
  parameter int PC_WIDTH  = 16
);
  import warp_scheduler_pkg::*;

  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int CNT_W = $clog2(NUM_WARPS) + 1;

  logic                start;
  logic [PC_WIDTH-1:0] base_pc;
  logic [CNT_W-1:0]    num_warps;
  logic                fetch_valid;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic                fetch_done;
  logic                decoded_halt;
  logic                decoded_sync;
  logic                decoded_mem_read_enable;
  logic                decoded_mem_write_enable;
  logic                lsu_done;
  logic                next_pc_valid;
  logic [PC_WIDTH-1:0] next_pc;
  warp_state_t         warp_state;
  logic [WID_W-1:0]    active_warp;
  logic                done;

  modport master (
    input  start, base_pc, num_warps, fetch_done, decoded_halt, decoded_sync,
           decoded_mem_read_enable, decoded_mem_write_enable, lsu_done,
           next_pc_valid, next_pc,
    output fetch_valid, fetch_pc, warp_state, active_warp, done
  );

  modport slave (
    output start, base_pc, num_warps, fetch_done, decoded_halt, decoded_sync,
           decoded_mem_read_enable, decoded_mem_write_enable, lsu_done,
           next_pc_valid, next_pc,
    input  fetch_valid, fetch_pc, warp_state, active_warp, done
  );

endinterface

// File: rtl/warp_scheduler_rr_picker.sv
// Combinational round-robin search: first set bit of mask strictly after ptr,
// wrapping. ptr itself is checked last, so a lone runnable warp re-grants itself.
//   mask      in  N        candidate warps
//   ptr       in  ID_W     last granted warp
//   grant     out ID_W     chosen warp id (0 when none)
//   any_valid out 1        mask had at least one bit set
module warp_scheduler_rr_picker #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant,
  output logic            any_valid
);

  always_comb begin
    int idx;
    grant     = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any_valid && mask[idx]) begin
        grant     = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: round-robin warp pick, phase FSM driving the
// shared warp_state (FETCH..UPDATE), per-warp PC/status, halt retirement and
// SYNC barrier release.
//   clk, reset  core clock, async active-high reset
//   bus         warp_scheduler_if master (launch, fetch, decoder flags, LSU,
//               redirect, warp_state/active_warp/done broadcast)
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int PC_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             reset,
  warp_scheduler_if.master bus
);

  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int CNT_W = $clog2(NUM_WARPS) + 1;
  localparam logic [CNT_W-1:0] NW_MAX = CNT_W'(NUM_WARPS);

  warp_state_t         state, state_nxt;
  warp_status_t        status [NUM_WARPS];
  logic [PC_WIDTH-1:0] pc     [NUM_WARPS];
  logic [WID_W-1:0]    active, rr_ptr, grant;
  logic                done_q, any_valid, release_sync, mem_op;
  logic [NUM_WARPS-1:0] ready_mask, sync_mask, live_mask, pick_mask;
  logic [CNT_W-1:0]    launch_n;

  assign launch_n = (bus.num_warps > NW_MAX) ? NW_MAX : bus.num_warps;
  assign mem_op   = bus.decoded_mem_read_enable | bus.decoded_mem_write_enable;

  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      ready_mask[i] = (status[i] == W_READY);
      sync_mask[i]  = (status[i] == W_SYNC);
      live_mask[i]  = (status[i] == W_READY) || (status[i] == W_SYNC);
    end
  end

  // Barrier opens once every enabled, non-halted warp is parked; halted warps
  // drop out of live_mask so a halt can complete a barrier.
  assign release_sync = (|sync_mask) && (sync_mask == live_mask);
  assign pick_mask    = release_sync ? (ready_mask | sync_mask) : ready_mask;

  warp_scheduler_rr_picker #(.N(NUM_WARPS), .ID_W(WID_W)) u_pick (
    .mask      (pick_mask),
    .ptr       (rr_ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      WARP_IDLE:     if (bus.start && launch_n != '0) state_nxt = WARP_SCHEDULE;
      // Nothing runnable here means every enabled warp has halted.
      WARP_SCHEDULE: state_nxt = any_valid ? WARP_FETCH : WARP_IDLE;
      WARP_FETCH:    if (bus.fetch_done) state_nxt = WARP_DECODE;
      WARP_DECODE:   state_nxt = WARP_REQUEST;
      WARP_REQUEST:  state_nxt = WARP_WAIT;
      WARP_WAIT:     if (!mem_op || bus.lsu_done) state_nxt = WARP_EXECUTE;
      WARP_EXECUTE:  state_nxt = WARP_UPDATE;
      WARP_UPDATE:   state_nxt = WARP_SCHEDULE;
      default:       state_nxt = WARP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= WARP_IDLE;
      active <= '0;
      rr_ptr <= WID_W'(NUM_WARPS - 1);
      done_q <= 1'b0;
      for (int i = 0; i < NUM_WARPS; i++) begin
        status[i] <= W_OFF;
        pc[i]     <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        WARP_IDLE: if (bus.start) begin
          // An empty launch completes immediately; done stays set otherwise
          // only until a real launch.
          done_q <= (launch_n == '0);
          rr_ptr <= WID_W'(NUM_WARPS - 1);
          for (int i = 0; i < NUM_WARPS; i++) begin
            if (CNT_W'(i) < launch_n) begin
              status[i] <= W_READY;
              pc[i]     <= bus.base_pc;
            end else begin
              status[i] <= W_OFF;
            end
          end
        end
        WARP_SCHEDULE: begin
          if (release_sync)
            for (int i = 0; i < NUM_WARPS; i++)
              if (sync_mask[i]) status[i] <= W_READY;
          if (any_valid) begin
            active <= grant;
            rr_ptr <= grant;
          end else begin
            done_q <= 1'b1;
          end
        end
        WARP_UPDATE: begin
          if (bus.decoded_halt) begin
            status[active] <= W_HALT;
          end else if (bus.decoded_sync) begin
            status[active] <= W_SYNC;
            pc[active]     <= pc[active] + 1'b1;
          end else if (bus.next_pc_valid) begin
            pc[active]     <= bus.next_pc;
          end else begin
            pc[active]     <= pc[active] + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.warp_state  = state;
  assign bus.active_warp = active;
  assign bus.fetch_valid = (state == WARP_FETCH);
  assign bus.fetch_pc    = pc[active];
  assign bus.done        = done_q;

endmodule
